// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART byte engine: bit-period math,
// ASCII constants used by the receive-side decoder and FSM encodings.
package uart_pkg;

   localparam logic [7:0] ASCII_CR   = 8'h0D;
   localparam logic [7:0] ASCII_LF   = 8'h0A;
   localparam logic [7:0] ASCII_W_UP = 8'h57;
   localparam logic [7:0] ASCII_W_LO = 8'h77;
   localparam logic [7:0] ASCII_R_UP = 8'h52;
   localparam logic [7:0] ASCII_R_LO = 8'h72;
   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam logic [7:0] ASCII_A_UP = 8'h41;
   localparam logic [7:0] ASCII_A_LO = 8'h61;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_HIGH
   } rx_state_t;

   // Bit period in clock cycles, rounded to nearest.
   function automatic int calc_bit_period(input int f_ck, input int baud);
      return (f_ck + baud / 2) / baud;
   endfunction

   // Hex digit value of an ASCII character; anything that is not a hex digit maps to 0.
   function automatic logic [3:0] ascii_hex(input logic [7:0] b);
      logic [3:0] value;
      value = 4'h0;
      if (b >= ASCII_ZERO && b <= 8'h39) begin
         value = 4'(b - ASCII_ZERO);
      end else if (b >= ASCII_A_UP && b <= 8'h46) begin
         value = 4'(b - ASCII_A_UP + 8'd10);
      end else if (b >= ASCII_A_LO && b <= 8'h66) begin
         value = 4'(b - ASCII_A_LO + 8'd10);
      end
      return value;
   endfunction

endpackage

// File: rtl/uart_txrx_core_if.sv
// Parser-side bundle of the UART byte engine: TX byte handshake,
// serial pins and the received byte with its classification flags.
interface uart_txrx_core_if;

   logic [7:0] BYTEs_i;
   logic       REQ_i;
   logic       TXD_o;
   logic       STB_o;
   logic       RXD_i;
   logic [7:0] BYTEs_o;
   logic [3:0] HEXs_o;
   logic       CRLF_DET_o;
   logic       W_DET_o;
   logic       R_DET_o;
   logic       DONE_o;

   modport master (
      output BYTEs_i, REQ_i, RXD_i,
      input  TXD_o, STB_o, BYTEs_o, HEXs_o, CRLF_DET_o, W_DET_o, R_DET_o, DONE_o
   );

   modport slave (
      input  BYTEs_i, REQ_i, RXD_i,
      output TXD_o, STB_o, BYTEs_o, HEXs_o, CRLF_DET_o, W_DET_o, R_DET_o, DONE_o
   );

endinterface

// File: rtl/uart_bit_timer.sv
// Free-running bit-period down-counter. A load restarts the period;
// full_tick marks the end of a period, half_tick its midpoint.
module uart_bit_timer #(
   parameter int N = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic full_tick,
   output logic half_tick
);

   localparam int           W    = $clog2(N);
   localparam logic [W-1:0] LAST = W'(N - 1);
   localparam logic [W-1:0] HALF = W'(N - N / 2);

   logic [W-1:0] count;

   // Count down from N-1 and wrap, so ticks recur every N cycles after a load.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= LAST;
      end else if (load || count == '0) begin
         count <= LAST;
      end else begin
         count <= count - W'(1);
      end
   end

   assign full_tick = (count == '0);
   assign half_tick = (count == HALF);

endmodule

// File: rtl/uart_txrx_core.sv
// 8N1 UART byte engine with independent TX and RX paths.
// Optional macro UART_RX_ASCII_DECODE_EN builds the ASCII hex/flag
// decoder on the received byte; without it those outputs read 0.
module uart_txrx_core
   import uart_pkg::*;
#(
   parameter int C_F_CK = 135_000_000,
   parameter int C_BAUD = 31_250
) (
   input logic              CK_i,
   input logic              XARST_i,
   uart_txrx_core_if.slave  bus
);

   localparam int N = calc_bit_period(C_F_CK, C_BAUD);

   tx_state_t  tx_state;
   logic [7:0] tx_shift;
   logic [2:0] tx_bit;
   logic       txd;
   logic       stb;
   logic       tx_load;
   logic       tx_full;
   logic       tx_half_unused;

   rx_state_t  rx_state;
   logic [7:0] rx_shift;
   logic [2:0] rx_bit;
   logic [7:0] rx_byte;
   logic       done;
   logic       rx_load;
   logic       rx_full;
   logic       rx_half;

`ifdef UART_RX_ASCII_DECODE_EN
   logic [3:0] hex_q;
   logic       crlf_q;
   logic       w_q;
   logic       r_q;
`endif

   assign tx_load = (tx_state == TX_IDLE) && bus.REQ_i;

   uart_bit_timer #(.N(N)) u_tx_timer (
      .clk       (CK_i),
      .rst_n     (XARST_i),
      .load      (tx_load),
      .full_tick (tx_full),
      .half_tick (tx_half_unused)
   );

   // TX frame sequencer: latch byte on acceptance, then shift start, 8 data bits LSB first and stop.
   always_ff @(posedge CK_i) begin
      if (!XARST_i) begin
         tx_state <= TX_IDLE;
         tx_shift <= '0;
         tx_bit   <= '0;
         txd      <= 1'b1;
         stb      <= 1'b1;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               if (bus.REQ_i) begin
                  tx_shift <= bus.BYTEs_i;
                  txd      <= 1'b0;
                  stb      <= 1'b0;
                  tx_state <= TX_START;
               end
            end
            TX_START: begin
               if (tx_full) begin
                  txd      <= tx_shift[0];
                  tx_shift <= {1'b0, tx_shift[7:1]};
                  tx_bit   <= '0;
                  tx_state <= TX_DATA;
               end
            end
            TX_DATA: begin
               if (tx_full) begin
                  if (tx_bit == 3'd7) begin
                     txd      <= 1'b1;
                     tx_state <= TX_STOP;
                  end else begin
                     txd      <= tx_shift[0];
                     tx_shift <= {1'b0, tx_shift[7:1]};
                     tx_bit   <= tx_bit + 3'd1;
                  end
               end
            end
            TX_STOP: begin
               if (tx_full) begin
                  stb      <= 1'b1;
                  tx_state <= TX_IDLE;
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   // The RX timer restarts on the first low sample and again at the start-bit midpoint,
   // so every later full tick lands in the middle of a bit.
   assign rx_load = ((rx_state == RX_IDLE) && !bus.RXD_i) ||
                    ((rx_state == RX_START) && rx_half);

   uart_bit_timer #(.N(N)) u_rx_timer (
      .clk       (CK_i),
      .rst_n     (XARST_i),
      .load      (rx_load),
      .full_tick (rx_full),
      .half_tick (rx_half)
   );

   // RX frame sampler: validate start bit, shift in data LSB first, commit only on a good stop bit.
   always_ff @(posedge CK_i) begin
      if (!XARST_i) begin
         rx_state <= RX_IDLE;
         rx_shift <= '0;
         rx_bit   <= '0;
         rx_byte  <= '0;
         done     <= 1'b0;
`ifdef UART_RX_ASCII_DECODE_EN
         hex_q    <= '0;
         crlf_q   <= 1'b0;
         w_q      <= 1'b0;
         r_q      <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (!bus.RXD_i) begin
                  rx_state <= RX_START;
               end
            end
            RX_START: begin
               if (rx_half) begin
                  if (bus.RXD_i) begin
                     rx_state <= RX_IDLE;
                  end else begin
                     rx_bit   <= '0;
                     rx_state <= RX_DATA;
                  end
               end
            end
            RX_DATA: begin
               if (rx_full) begin
                  rx_shift <= {bus.RXD_i, rx_shift[7:1]};
                  if (rx_bit == 3'd7) begin
                     rx_state <= RX_STOP;
                  end else begin
                     rx_bit <= rx_bit + 3'd1;
                  end
               end
            end
            RX_STOP: begin
               if (rx_full) begin
                  if (bus.RXD_i) begin
                     rx_byte  <= rx_shift;
                     done     <= 1'b1;
`ifdef UART_RX_ASCII_DECODE_EN
                     hex_q    <= ascii_hex(rx_shift);
                     crlf_q   <= (rx_shift == ASCII_CR) || (rx_shift == ASCII_LF);
                     w_q      <= (rx_shift == ASCII_W_UP) || (rx_shift == ASCII_W_LO);
                     r_q      <= (rx_shift == ASCII_R_UP) || (rx_shift == ASCII_R_LO);
`endif
                     rx_state <= RX_IDLE;
                  end else begin
                     rx_state <= RX_WAIT_HIGH;
                  end
               end
            end
            RX_WAIT_HIGH: begin
               if (bus.RXD_i) begin
                  rx_state <= RX_IDLE;
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   assign bus.TXD_o   = txd;
   assign bus.STB_o   = stb;
   assign bus.BYTEs_o = rx_byte;
   assign bus.DONE_o  = done;

`ifdef UART_RX_ASCII_DECODE_EN
   assign bus.HEXs_o     = hex_q;
   assign bus.CRLF_DET_o = crlf_q;
   assign bus.W_DET_o    = w_q;
   assign bus.R_DET_o    = r_q;
`else
   assign bus.HEXs_o     = 4'h0;
   assign bus.CRLF_DET_o = 1'b0;
   assign bus.W_DET_o    = 1'b0;
   assign bus.R_DET_o    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_txrx_core.sv
// Directed bench for uart_txrx_core at N=10 (1000 Hz clock, 100 baud).
// Decode expectations follow UART_RX_ASCII_DECODE_EN: decoded values when
// defined, zeros otherwise.
module tb_uart_txrx_core;

`ifdef UART_RX_ASCII_DECODE_EN
   localparam bit DEC = 1'b1;
`else
   localparam bit DEC = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic loopback;
   logic rxd_drive;
   int   tests_run = 0;
   int   tests_failed = 0;
   int   done_count;

   logic [7:0] rx_vec   [6] = '{8'h61, 8'h46, 8'h37, 8'h57, 8'h72, 8'h0D};
   logic [3:0] hex_vec  [6] = '{4'hA, 4'hF, 4'h7, 4'h0, 4'h0, 4'h0};
   logic [2:0] flag_vec [6] = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b001, 3'b100};

   uart_txrx_core_if bus ();

   assign bus.RXD_i = loopback ? bus.TXD_o : rxd_drive;

   uart_txrx_core #(.C_F_CK(1000), .C_BAUD(100)) dut (
      .CK_i    (clk),
      .XARST_i (rst_n),
      .bus     (bus)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Drive one serial frame on RXD (start, data LSB first, given stop level), then idle high;
   // counts DONE pulses seen throughout.
   task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
      logic [9:0] frame;
      frame = {stop_bit, b, 1'b0};
      done_count = 0;
      for (int i = 0; i < 10; i++) begin
         for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.DONE_o) done_count++;
            rxd_drive = frame[i];
         end
      end
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (bus.DONE_o) done_count++;
         rxd_drive = 1'b1;
      end
   endtask

   // Request one TX frame and compare every line cycle against the hand-written bit pattern.
   task automatic sendTx(input logic [7:0] b, input logic [9:0] pattern);
      @(negedge clk);
      bus.BYTEs_i = b;
      bus.REQ_i   = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (i == 0) bus.REQ_i = 1'b0;
         checkOutput("tx_txd", 32'(bus.TXD_o), 32'(pattern[i / 10]));
         if (i % 10 == 0) checkOutput("tx_stb_busy", 32'(bus.STB_o), 32'd0);
      end
      @(negedge clk);
      checkOutput("tx_stb_ready", 32'(bus.STB_o), 32'd1);
      checkOutput("tx_txd_idle", 32'(bus.TXD_o), 32'd1);
   endtask

   initial begin
      logic       got_done;
      logic [7:0] lb_byte;
      int         waited;

      rst_n       = 1'b0;
      loopback    = 1'b0;
      rxd_drive   = 1'b1;
      bus.REQ_i   = 1'b0;
      bus.BYTEs_i = 8'h00;
      repeat (3) @(negedge clk);
      checkOutput("rst_txd", 32'(bus.TXD_o), 32'd1);
      checkOutput("rst_stb", 32'(bus.STB_o), 32'd1);
      checkOutput("rst_byte", 32'(bus.BYTEs_o), 32'd0);
      checkOutput("rst_hex", 32'(bus.HEXs_o), 32'd0);
      checkOutput("rst_flags", 32'({bus.CRLF_DET_o, bus.W_DET_o, bus.R_DET_o}), 32'd0);
      checkOutput("rst_done", 32'(bus.DONE_o), 32'd0);
      rst_n = 1'b1;

      // 0x55: 0,1,0,1,0,1,0,1,0,1 in line order
      sendTx(8'h55, 10'h2AA);

      for (int k = 0; k < 6; k++) begin
         applyStimulus(rx_vec[k], 1'b1);
         checkOutput("rx_done", 32'(done_count), 32'd1);
         checkOutput("rx_byte", 32'(bus.BYTEs_o), 32'(rx_vec[k]));
         checkOutput("rx_hex", 32'(bus.HEXs_o), DEC ? 32'(hex_vec[k]) : 32'd0);
         checkOutput("rx_flags", 32'({bus.CRLF_DET_o, bus.W_DET_o, bus.R_DET_o}),
                     DEC ? 32'(flag_vec[k]) : 32'd0);
      end

      done_count = 0;
      for (int c = 0; c < 18; c++) begin
         @(negedge clk);
         if (bus.DONE_o) done_count++;
         rxd_drive = (c < 3) ? 1'b0 : 1'b1;
      end
      checkOutput("glitch_no_done", 32'(done_count), 32'd0);
      checkOutput("glitch_byte_held", 32'(bus.BYTEs_o), 32'h0D);
      applyStimulus(8'h3C, 1'b1);
      checkOutput("after_glitch_done", 32'(done_count), 32'd1);
      checkOutput("after_glitch_byte", 32'(bus.BYTEs_o), 32'h3C);

      applyStimulus(8'hA5, 1'b0);
      checkOutput("frame_err_no_done", 32'(done_count), 32'd0);
      checkOutput("frame_err_byte_held", 32'(bus.BYTEs_o), 32'h3C);
      applyStimulus(8'h5A, 1'b1);
      checkOutput("after_frame_err_done", 32'(done_count), 32'd1);
      checkOutput("after_frame_err_byte", 32'(bus.BYTEs_o), 32'h5A);

      @(negedge clk);
      bus.BYTEs_i = 8'hC3;
      bus.REQ_i   = 1'b1;
      @(negedge clk);
      bus.REQ_i = 1'b0;
      repeat (35) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("midrst_txd", 32'(bus.TXD_o), 32'd1);
      checkOutput("midrst_stb", 32'(bus.STB_o), 32'd1);
      rst_n = 1'b1;
      // 0x96: 0, 0,1,1,0,1,0,0,1, 1 in line order
      sendTx(8'h96, 10'h32C);

      loopback = 1'b1;
      for (int v = 0; v < 256; v++) begin
         waited = 0;
         while (!bus.STB_o && waited < 300) begin
            @(negedge clk);
            waited++;
         end
         checkOutput("lb_stb_ready", 32'(bus.STB_o), 32'd1);
         bus.BYTEs_i = 8'(v);
         bus.REQ_i   = 1'b1;
         got_done    = 1'b0;
         lb_byte     = 8'h00;
         for (int c = 0; c < 200 && !got_done; c++) begin
            @(negedge clk);
            if (!bus.STB_o) bus.REQ_i = 1'b0;
            if (bus.DONE_o) begin
               got_done = 1'b1;
               lb_byte  = bus.BYTEs_o;
            end
         end
         bus.REQ_i = 1'b0;
         checkOutput("lb_done", 32'(got_done), 32'd1);
         checkOutput("lb_byte", 32'(lb_byte), 32'(v));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
